alu_op_sequencer: RTL and testbench

//  Drives the alu block's combinational interface (AC, DR, code, EI -> DATAOUT, EO, INC).

---
 rtl/mbc_pkg.sv | 27 ++
 rtl/alu_op_sequencer_if.sv | 46 ++++
 rtl/alu_op_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mbc_pkg.sv
// rtl/mbc_pkg.sv - ALU op codes, code legality check and sequencer state type
package mbc_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_LDA = 4'b0010;
  localparam logic [3:0] ALU_CLA = 4'b0011;
  localparam logic [3:0] ALU_CLE = 4'b0100;
  localparam logic [3:0] ALU_CMA = 4'b0101;
  localparam logic [3:0] ALU_CME = 4'b0110;
  localparam logic [3:0] ALU_CIR = 4'b0111;
  localparam logic [3:0] ALU_CIL = 4'b1000;
  localparam logic [3:0] ALU_INC = 4'b1001;
  localparam logic [3:0] ALU_OPC = 4'b1100;
  localparam logic [3:0] ALU_OPD = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  function automatic logic is_legal_code(input logic [3:0] code);
    return (code <= ALU_INC) || (code == ALU_OPC) || (code == ALU_OPD);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request, result and ALU-side signals of the op sequencer
interface alu_op_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int CODE_W = 4,
  parameter int CNT_W  = 4
);
  logic              op_valid;
  logic              op_ready;
  logic [CODE_W-1:0] op_code;
  logic [DATA_W-1:0] op_dr;
  logic [CNT_W-1:0]  op_count;

  logic [DATA_W-1:0] alu_ac;
  logic [DATA_W-1:0] alu_dr;
  logic [CODE_W-1:0] alu_code;
  logic              alu_ei;
  logic [DATA_W-1:0] alu_dataout;
  logic              alu_eo;
  logic              alu_inc;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_ac;
  logic              res_e;
  logic              res_zero;
  logic              res_inc;
  logic              res_err;

  modport slave (
    input  op_valid, op_code, op_dr, op_count,
    input  alu_dataout, alu_eo, alu_inc,
    input  res_ready,
    output op_ready,
    output alu_ac, alu_dr, alu_code, alu_ei,
    output res_valid, res_ac, res_e, res_zero, res_inc, res_err
  );

  modport master (
    output op_valid, op_code, op_dr, op_count,
    output alu_dataout, alu_eo, alu_inc,
    output res_ready,
    input  op_ready,
    input  alu_ac, alu_dr, alu_code, alu_ei,
    input  res_valid, res_ac, res_e, res_zero, res_inc, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - owns AC/E, issues one request to the ALU 1..16 times and returns the result
module alu_op_sequencer
  import mbc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CODE_W  = 4,
  parameter int CNT_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave seq_if,
  output logic [DATA_W-1:0] ac_q,
  output logic              e_q
);

  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] ac_d;
  logic              e_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              inc_acc_q, inc_acc_d;

  // alu_dr/alu_code registers double as the latched request operands
  logic [DATA_W-1:0] alu_ac_q, alu_ac_d;
  logic [DATA_W-1:0] alu_dr_q, alu_dr_d;
  logic [CODE_W-1:0] alu_code_q, alu_code_d;
  logic              alu_ei_q, alu_ei_d;

  logic [DATA_W-1:0] res_ac_q, res_ac_d;
  logic              res_e_q, res_e_d;
  logic              res_zero_q, res_zero_d;
  logic              res_inc_q, res_inc_d;
  logic              res_err_q, res_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ac_q       <= '0;
      e_q        <= 1'b0;
      cnt_q      <= '0;
      lat_q      <= '0;
      inc_acc_q  <= 1'b0;
      alu_ac_q   <= '0;
      alu_dr_q   <= '0;
      alu_code_q <= '0;
      alu_ei_q   <= 1'b0;
      res_ac_q   <= '0;
      res_e_q    <= 1'b0;
      res_zero_q <= 1'b0;
      res_inc_q  <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ac_q       <= ac_d;
      e_q        <= e_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      inc_acc_q  <= inc_acc_d;
      alu_ac_q   <= alu_ac_d;
      alu_dr_q   <= alu_dr_d;
      alu_code_q <= alu_code_d;
      alu_ei_q   <= alu_ei_d;
      res_ac_q   <= res_ac_d;
      res_e_q    <= res_e_d;
      res_zero_q <= res_zero_d;
      res_inc_q  <= res_inc_d;
      res_err_q  <= res_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ac_d       = ac_q;
    e_d        = e_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    inc_acc_d  = inc_acc_q;
    alu_ac_d   = alu_ac_q;
    alu_dr_d   = alu_dr_q;
    alu_code_d = alu_code_q;
    alu_ei_d   = alu_ei_q;
    res_ac_d   = res_ac_q;
    res_e_d    = res_e_q;
    res_zero_d = res_zero_q;
    res_inc_d  = res_inc_q;
    res_err_d  = res_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (seq_if.op_valid) begin
          cnt_d     = seq_if.op_count;
          lat_d     = '0;
          inc_acc_d = 1'b0;
          if (is_legal_code(4'(seq_if.op_code))) begin
            alu_ac_d   = ac_q;
            alu_dr_d   = seq_if.op_dr;
            alu_code_d = seq_if.op_code;
            alu_ei_d   = e_q;
            state_d    = ST_ISSUE;
          end else begin
            res_ac_d   = ac_q;
            res_e_d    = e_q;
            res_zero_d = (ac_q == '0);
            res_inc_d  = 1'b0;
            res_err_d  = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end

      ST_ISSUE: begin
        if (lat_q == LAT_LAST) begin
          lat_d     = '0;
          ac_d      = seq_if.alu_dataout;
          e_d       = seq_if.alu_eo;
          inc_acc_d = inc_acc_q | seq_if.alu_inc;
          if (cnt_q != '0) begin
            // next pass sees the value just written back
            cnt_d    = cnt_q - CNT_W'(1);
            alu_ac_d = seq_if.alu_dataout;
            alu_ei_d = seq_if.alu_eo;
          end else begin
            res_ac_d   = seq_if.alu_dataout;
            res_e_d    = seq_if.alu_eo;
            res_zero_d = (seq_if.alu_dataout == '0);
            res_inc_d  = inc_acc_q | seq_if.alu_inc;
            res_err_d  = 1'b0;
            state_d    = ST_DONE;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      ST_DONE: begin
        if (seq_if.res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign seq_if.op_ready  = (state_q == ST_IDLE);
  assign seq_if.res_valid = (state_q == ST_DONE);
  assign seq_if.alu_ac    = alu_ac_q;
  assign seq_if.alu_dr    = alu_dr_q;
  assign seq_if.alu_code  = alu_code_q;
  assign seq_if.alu_ei    = alu_ei_q;
  assign seq_if.res_ac    = res_ac_q;
  assign seq_if.res_e     = res_e_q;
  assign seq_if.res_zero  = res_zero_q;
  assign seq_if.res_inc   = res_inc_q;
  assign seq_if.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench for alu_op_sequencer with a behavioural basic-computer ALU
module tb_alu_op_sequencer;
  import mbc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ac_q;
  logic        e_q;
  int          n_total = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(16), .CODE_W(4), .CNT_W(4)) bus ();

  alu_op_sequencer #(.DATA_W(16), .CODE_W(4), .CNT_W(4), .ALU_LAT(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (bus.slave),
    .ac_q   (ac_q),
    .e_q    (e_q)
  );

  // behavioural ALU: {E,AC} in, {E,AC} out, INC flags increment carry
  logic [16:0] alu_res;
  logic        alu_carry;
  always_comb begin
    alu_res   = {bus.alu_ei, bus.alu_ac};
    alu_carry = 1'b0;
    case (bus.alu_code)
      ALU_AND: alu_res[15:0] = bus.alu_ac & bus.alu_dr;
      ALU_ADD: alu_res = {1'b0, bus.alu_ac} + {1'b0, bus.alu_dr};
      ALU_LDA: alu_res[15:0] = bus.alu_dr;
      ALU_CLA: alu_res[15:0] = 16'h0000;
      ALU_CLE: alu_res[16] = 1'b0;
      ALU_CMA: alu_res[15:0] = ~bus.alu_ac;
      ALU_CME: alu_res[16] = ~bus.alu_ei;
      ALU_CIR: alu_res = {bus.alu_ac[0], bus.alu_ei, bus.alu_ac[15:1]};
      ALU_CIL: alu_res = {bus.alu_ac[15], bus.alu_ac[14:0], bus.alu_ei};
      ALU_INC: begin
        alu_res[15:0] = bus.alu_ac + 16'h0001;
        alu_carry     = (bus.alu_ac == 16'hFFFF);
      end
      default: ;
    endcase
  end
  assign bus.alu_dataout = alu_res[15:0];
  assign bus.alu_eo      = alu_res[16];
  assign bus.alu_inc     = alu_carry;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // called #1 after an edge in IDLE; returns cycles from accept to res_valid
  task automatic run_op(input logic [3:0] code, input logic [15:0] dr, input logic [3:0] cnt,
                        output int lat, output logic busy_ok);
    int guard = 0;
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_dr    = dr;
    bus.op_count = cnt;
    while (!bus.op_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!bus.op_ready) check("accept_timeout", 32'd0, 32'd1);
    tick();
    bus.op_valid = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.res_valid && lat < 40) begin
      if (bus.op_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (bus.op_ready) busy_ok = 1'b0;
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  int          lat;
  logic        busy_ok;
  logic        stable_ok;
  logic        seen;
  logic [3:0]  saved_code;

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_code   = '0;
    bus.op_dr     = '0;
    bus.op_count  = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    check("rst_op_ready", 32'(bus.op_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_ac", 32'(ac_q), 32'h0);
    check("rst_e", 32'(e_q), 32'h0);
    check("rst_alu_code", 32'(bus.alu_code), 32'h0);
    check("rst_res_ac", 32'(bus.res_ac), 32'h0);

    run_op(ALU_LDA, 16'h1234, 4'd0, lat, busy_ok);
    check("t1_lat", 32'(lat), 32'd2);
    check("t1_res_ac", 32'(bus.res_ac), 32'h1234);
    check("t1_res_e", 32'(bus.res_e), 32'h0);
    check("t1_res_zero", 32'(bus.res_zero), 32'h0);
    check("t1_res_err", 32'(bus.res_err), 32'h0);
    consume();
    check("t1_ready_after", 32'(bus.op_ready), 32'd1);

    run_op(ALU_ADD, 16'hEDCC, 4'd0, lat, busy_ok);
    check("t2_res_ac", 32'(bus.res_ac), 32'h0000);
    check("t2_res_e", 32'(bus.res_e), 32'h1);
    check("t2_res_zero", 32'(bus.res_zero), 32'h1);
    consume();

    run_op(ALU_LDA, 16'h8001, 4'd0, lat, busy_ok);
    consume();
    run_op(ALU_CLE, 16'h0000, 4'd0, lat, busy_ok);
    consume();
    check("t3_pre_ac", 32'(ac_q), 32'h8001);
    check("t3_pre_e", 32'(e_q), 32'h0);
    run_op(ALU_CIL, 16'h0000, 4'd3, lat, busy_ok);
    check("t3_lat", 32'(lat), 32'd5);
    check("t3_busy", 32'(busy_ok), 32'd1);
    check("t3_res_ac", 32'(bus.res_ac), 32'h0014);
    check("t3_res_e", 32'(bus.res_e), 32'h0);
    consume();

    saved_code = bus.alu_code;
    run_op(4'b1010, 16'hBEEF, 4'd2, lat, busy_ok);
    check("t4_lat", 32'(lat), 32'd1);
    check("t4_res_err", 32'(bus.res_err), 32'd1);
    check("t4_res_inc", 32'(bus.res_inc), 32'd0);
    check("t4_res_ac", 32'(bus.res_ac), 32'h0014);
    check("t4_ac", 32'(ac_q), 32'h0014);
    check("t4_e", 32'(e_q), 32'h0);
    check("t4_alu_code", 32'(bus.alu_code), 32'(ALU_CIL));
    check("t4_alu_code_saved", 32'(bus.alu_code), 32'(saved_code));
    consume();

    run_op(ALU_LDA, 16'hFFFF, 4'd0, lat, busy_ok);
    consume();
    run_op(ALU_INC, 16'h0000, 4'd1, lat, busy_ok);
    check("inc_lat", 32'(lat), 32'd3);
    check("inc_res_ac", 32'(bus.res_ac), 32'h0001);
    check("inc_res_inc", 32'(bus.res_inc), 32'd1);
    check("inc_res_err", 32'(bus.res_err), 32'd0);
    consume();
    run_op(ALU_CMA, 16'h0000, 4'd0, lat, busy_ok);
    check("cma_res_ac", 32'(bus.res_ac), 32'hFFFE);
    check("cma_res_inc_clr", 32'(bus.res_inc), 32'd0);
    consume();

    run_op(ALU_LDA, 16'h00AA, 4'd0, lat, busy_ok);
    bus.op_valid = 1'b1;
    bus.op_code  = ALU_LDA;
    bus.op_dr    = 16'h5555;
    bus.op_count = 4'd0;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!bus.res_valid || bus.res_ac !== 16'h00AA || bus.op_ready || ac_q !== 16'h00AA)
        stable_ok = 1'b0;
    end
    check("t5_stable", 32'(stable_ok), 32'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t5_valid_drop", 32'(bus.res_valid), 32'd0);
    check("t5_ready_back", 32'(bus.op_ready), 32'd1);
    tick();
    bus.op_valid = 1'b0;
    check("t5_accepted", 32'(bus.op_ready), 32'd0);
    tick();
    check("t5_new_valid", 32'(bus.res_valid), 32'd1);
    check("t5_new_res_ac", 32'(bus.res_ac), 32'h5555);
    consume();

    bus.op_valid = 1'b1;
    bus.op_code  = ALU_LDA;
    bus.op_dr    = 16'h1111;
    bus.op_count = 4'd7;
    tick();
    bus.op_valid = 1'b0;
    repeat (3) tick();
    check("t6_pre_ac", 32'(ac_q), 32'h1111);
    rst_n = 1'b0;
    #2;
    check("t6_rst_ac", 32'(ac_q), 32'h0);
    check("t6_rst_e", 32'(e_q), 32'h0);
    check("t6_rst_ready", 32'(bus.op_ready), 32'd1);
    check("t6_rst_alu_ac", 32'(bus.alu_ac), 32'h0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.res_valid) seen = 1'b1;
    end
    check("t6_no_result", 32'(seen), 32'd0);
    run_op(ALU_LDA, 16'h1234, 4'd0, lat, busy_ok);
    check("t6_lat", 32'(lat), 32'd2);
    check("t6_res_ac", 32'(bus.res_ac), 32'h1234);
    check("t6_res_e", 32'(bus.res_e), 32'h0);
    consume();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
